// File: rtl/cnn_conv_pkg.sv
// Shared types, constants and size helpers for the 2-D convolution layer.
package cnn_conv_pkg;

  localparam int FRAC_BITS = 16;
  localparam int ACC_WIDTH = 64;

  typedef enum logic {
    ST_LOAD    = 1'b0,
    ST_COMPUTE = 1'b1
  } state_e;

  function automatic int span_f(input int kernel, input int rate);
    return (kernel - 1) * rate + 1;
  endfunction

  function automatic int out_dim_f(input int image, input int kernel, input int rate);
    return image - span_f(kernel, rate) + 1;
  endfunction

  function automatic int addr_w_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cnn_mac_q16.sv
// Q16.16 multiply-accumulate: registered product, 64-bit accumulator cleared on
// the first tap, arithmetic shift back to Q16.16 with 32-bit saturation.
module cnn_mac_q16
  import cnn_conv_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_i,
  input  logic               first_i,
  input  logic               last_i,
  input  logic signed [31:0] pxl_i,
  input  logic signed [31:0] wgt_i,
  output logic signed [31:0] result_o,
  output logic               done_o
);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = 64'shFFFF_FFFF_8000_0000;

  logic signed [ACC_WIDTH-1:0] prod_q, acc_q, shifted;
  logic                        mul_v_q, mul_first_q, mul_last_q, done_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q      <= '0;
      acc_q       <= '0;
      mul_v_q     <= 1'b0;
      mul_first_q <= 1'b0;
      mul_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      prod_q      <= ACC_WIDTH'(pxl_i) * ACC_WIDTH'(wgt_i);
      mul_v_q     <= valid_i;
      mul_first_q <= first_i;
      mul_last_q  <= last_i;
      if (mul_v_q) acc_q <= mul_first_q ? prod_q : acc_q + prod_q;
      done_q      <= mul_v_q && mul_last_q;
    end
  end

  assign shifted = acc_q >>> FRAC_BITS;

  // NOTE: every branch assigns result_o, so no latch is inferred.
  always_comb begin
    if (shifted > SAT_MAX)      result_o = 32'sh7FFF_FFFF;
    else if (shifted < SAT_MIN) result_o = 32'sh8000_0000;
    else                        result_o = shifted[31:0];
  end

  assign done_o = done_q;

endmodule

// File: rtl/cnn_conv_7x7_64.sv
// Buffered 2-D convolution: loads a full frame and weight set, then walks every
// output tap through a single pipelined MAC and streams out Q16.16 results.
module cnn_conv_7x7_64
  import cnn_conv_pkg::*;
#(
  parameter int IMAGE_WIDTH     = 1224,
  parameter int IMAGE_HEIGHT    = 1224,
  parameter int CHANNEL_NUM_IN  = 3,
  parameter int CHANNEL_NUM_OUT = 64,
  parameter int KERNEL          = 7,
  parameter int RATE            = 1,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  valid_weight_in,
  input  logic [DATA_WIDTH-1:0] weight_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out
);

  localparam int OUT_W      = out_dim_f(IMAGE_WIDTH, KERNEL, RATE);
  localparam int OUT_H      = out_dim_f(IMAGE_HEIGHT, KERNEL, RATE);
  localparam int PIX_NUM    = CHANNEL_NUM_IN * IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int WEIGHT_NUM = CHANNEL_NUM_OUT * CHANNEL_NUM_IN * KERNEL * KERNEL;
  localparam int PA_W = addr_w_f(PIX_NUM);
  localparam int WA_W = addr_w_f(WEIGHT_NUM);
  localparam int PC_W = addr_w_f(PIX_NUM + 1);
  localparam int WC_W = addr_w_f(WEIGHT_NUM + 1);
  localparam int CO_W = addr_w_f(CHANNEL_NUM_OUT);
  localparam int CI_W = addr_w_f(CHANNEL_NUM_IN);
  localparam int OX_W = addr_w_f(OUT_W);
  localparam int OY_W = addr_w_f(OUT_H);
  localparam int K_W  = addr_w_f(KERNEL);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pix_cnt_q;
  logic [WC_W-1:0]   wgt_cnt_q;
  logic [CO_W-1:0]   co_q, co_d;
  logic [OY_W-1:0]   oy_q, oy_d;
  logic [OX_W-1:0]   ox_q, ox_d;
  logic [CI_W-1:0]   ci_q, ci_d;
  logic [K_W-1:0]    ky_q, ky_d, kx_q, kx_d;
  logic              pix_full, wgt_full, pix_we, wgt_we, computing;
  logic              kx_last, ky_last, ci_last, ox_last, oy_last, co_last;
  logic              first_tap, last_tap, last_out;
  logic [PA_W-1:0]   pix_addr;
  logic [WA_W-1:0]   wgt_addr;
  logic [DATA_WIDTH-1:0] pix_mem [PIX_NUM];
  logic [DATA_WIDTH-1:0] wgt_mem [WEIGHT_NUM];
  logic [DATA_WIDTH-1:0] pix_rd_q, wgt_rd_q;
  logic              rd_v_q, rd_first_q, rd_last_q;
  logic signed [DATA_WIDTH-1:0] mac_result;
  logic              mac_done;

  assign computing = (state_q == ST_COMPUTE);
  assign pix_full  = (pix_cnt_q == PC_W'(PIX_NUM));
  assign wgt_full  = (wgt_cnt_q == WC_W'(WEIGHT_NUM));
  assign pix_we    = !computing && valid_in && !pix_full;
  assign wgt_we    = !computing && valid_weight_in && !wgt_full;

  assign kx_last   = (kx_q == K_W'(KERNEL - 1));
  assign ky_last   = (ky_q == K_W'(KERNEL - 1));
  assign ci_last   = (ci_q == CI_W'(CHANNEL_NUM_IN - 1));
  assign ox_last   = (ox_q == OX_W'(OUT_W - 1));
  assign oy_last   = (oy_q == OY_W'(OUT_H - 1));
  assign co_last   = (co_q == CO_W'(CHANNEL_NUM_OUT - 1));
  assign first_tap = (kx_q == '0) && (ky_q == '0) && (ci_q == '0);
  assign last_tap  = kx_last && ky_last && ci_last;
  assign last_out  = ox_last && oy_last && co_last;

  // Nested odometer: kx fastest, co slowest; full wrap leaves every counter at 0.
  always_comb begin
    state_d = state_q;
    co_d = co_q; oy_d = oy_q; ox_d = ox_q;
    ci_d = ci_q; ky_d = ky_q; kx_d = kx_q;
    if (!computing) begin
      if (pix_full && wgt_full) state_d = ST_COMPUTE;
    end else begin
      if (last_tap && last_out) state_d = ST_LOAD;
      kx_d = kx_last ? '0 : kx_q + 1'b1;
      if (kx_last) begin
        ky_d = ky_last ? '0 : ky_q + 1'b1;
        if (ky_last) begin
          ci_d = ci_last ? '0 : ci_q + 1'b1;
          if (ci_last) begin
            ox_d = ox_last ? '0 : ox_q + 1'b1;
            if (ox_last) begin
              oy_d = oy_last ? '0 : oy_q + 1'b1;
              if (oy_last) co_d = co_last ? '0 : co_q + 1'b1;
            end
          end
        end
      end
    end
  end

  assign pix_addr = PA_W'((int'(ci_q) * IMAGE_HEIGHT + int'(oy_q) + int'(ky_q) * RATE)
                          * IMAGE_WIDTH + int'(ox_q) + int'(kx_q) * RATE);
  assign wgt_addr = WA_W'(((int'(co_q) * CHANNEL_NUM_IN + int'(ci_q)) * KERNEL
                           + int'(ky_q)) * KERNEL + int'(kx_q));

  // NOTE: the buffers are plain RAMs and are deliberately not reset; every
  // frame reloads them in full before any location is read.
  always_ff @(posedge clk) begin
    if (pix_we) pix_mem[pix_cnt_q[PA_W-1:0]] <= pxl_in;
    if (wgt_we) wgt_mem[wgt_cnt_q[WA_W-1:0]] <= weight_in;
    pix_rd_q <= pix_mem[pix_addr];
    wgt_rd_q <= wgt_mem[wgt_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      pix_cnt_q  <= '0;
      wgt_cnt_q  <= '0;
      co_q <= '0; oy_q <= '0; ox_q <= '0;
      ci_q <= '0; ky_q <= '0; kx_q <= '0;
      rd_v_q     <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
      pxl_out    <= '0;
      valid_out  <= 1'b0;
    end else begin
      state_q <= state_d;
      co_q <= co_d; oy_q <= oy_d; ox_q <= ox_d;
      ci_q <= ci_d; ky_q <= ky_d; kx_q <= kx_d;
      rd_v_q     <= computing;
      rd_first_q <= first_tap;
      rd_last_q  <= last_tap;
      if (computing && last_tap && last_out) begin
        pix_cnt_q <= '0;
        wgt_cnt_q <= '0;
      end else begin
        if (pix_we) pix_cnt_q <= pix_cnt_q + 1'b1;
        if (wgt_we) wgt_cnt_q <= wgt_cnt_q + 1'b1;
      end
      valid_out <= mac_done;
      if (mac_done) pxl_out <= mac_result;
    end
  end

  cnn_mac_q16 u_mac (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (rd_v_q),
    .first_i  (rd_first_q),
    .last_i   (rd_last_q),
    .pxl_i    (pix_rd_q),
    .wgt_i    (wgt_rd_q),
    .result_o (mac_result),
    .done_o   (mac_done)
  );

endmodule

// File: tb/tb_cnn_conv_7x7_64.sv
// Directed bench for cnn_conv_7x7_64 on an 8x8, 1-in, 2-out, 3x3 configuration,
// plus a dilation-2 instance; expected words are hand-computed constants.
module tb_cnn_conv_7x7_64;

  localparam int PN   = 64;
  localparam int WN   = 18;
  localparam int NOUT = 72;
  localparam int TAPS = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0, valid_weight_in = 1'b0, use_d = 1'b0;
  logic [31:0] pxl_in = '0, weight_in = '0;
  logic [31:0] pxl_out, pxl_out_d;
  logic        valid_out, valid_out_d;

  always #5 clk = ~clk;

  cnn_conv_7x7_64 #(
    .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .CHANNEL_NUM_IN(1), .CHANNEL_NUM_OUT(2),
    .KERNEL(3), .RATE(1), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in & ~use_d), .pxl_in(pxl_in),
    .valid_weight_in(valid_weight_in & ~use_d), .weight_in(weight_in),
    .pxl_out(pxl_out), .valid_out(valid_out)
  );

  cnn_conv_7x7_64 #(
    .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .CHANNEL_NUM_IN(1), .CHANNEL_NUM_OUT(2),
    .KERNEL(3), .RATE(2), .DATA_WIDTH(32)
  ) dut_d (
    .clk(clk), .reset(reset),
    .valid_in(valid_in & use_d), .pxl_in(pxl_in),
    .valid_weight_in(valid_weight_in & use_d), .weight_in(weight_in),
    .pxl_out(pxl_out_d), .valid_out(valid_out_d)
  );

  int          cyc = 0;
  int          cap_n = 0, capd_n = 0;
  logic [31:0] cap [2048];
  int          cap_t [2048];
  logic [31:0] capd [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out) begin
      if (cap_n < 2048) begin
        cap[cap_n]   <= pxl_out;
        cap_t[cap_n] <= cyc;
      end
      cap_n <= cap_n + 1;
    end
    if (valid_out_d) begin
      if (capd_n < 64) capd[capd_n] <= pxl_out_d;
      capd_n <= capd_n + 1;
    end
  end

  int          n_vec = 0, n_err = 0;
  logic [31:0] pix [PN];
  logic [31:0] wgt [WN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [31:0] pv, input logic [31:0] w0, input logic [31:0] w1);
    for (int i = 0; i < PN; i++) pix[i] = pv;
    for (int i = 0; i < TAPS; i++) begin
      wgt[i]        = w0;
      wgt[TAPS + i] = w1;
    end
  endtask

  // pg/wg: issue a word every pg/wg cycles; junk: stream garbage once a stream is
  // complete and for 40 cycles after both, which must all be dropped.
  task automatic load(input int pg, input int wg, input bit junk);
    int pi = 0, wi = 0, c = 0;
    while (pi < PN || wi < WN) begin
      @(negedge clk);
      if (pi < PN && (c % pg) == 0) begin
        valid_in = 1'b1; pxl_in = pix[pi]; pi++;
      end else if (junk && pi >= PN) begin
        valid_in = 1'b1; pxl_in = 32'h7FFF0000;
      end else valid_in = 1'b0;
      if (wi < WN && (c % wg) == 0) begin
        valid_weight_in = 1'b1; weight_in = wgt[wi]; wi++;
      end else if (junk && wi >= WN) begin
        valid_weight_in = 1'b1; weight_in = 32'h7FFF0000;
      end else valid_weight_in = 1'b0;
      c++;
    end
    if (junk) begin
      repeat (40) begin
        @(negedge clk);
        valid_in = 1'b1; pxl_in = 32'h7FFF0000;
        valid_weight_in = 1'b1; weight_in = 32'h80000000;
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    valid_weight_in = 1'b0;
  endtask

  task automatic wait_out(input int base, input int n);
    int c = 0;
    while (cap_n - base < n && c < 3000) begin
      @(posedge clk);
      c++;
    end
    repeat (20) @(posedge clk);
    check("out_count", 32'(cap_n - base), 32'(n));
  endtask

  task automatic check_frame(input string tag, input int base,
                             input logic [31:0] v0, input logic [31:0] v1);
    for (int i = 0; i < NOUT; i++) check(tag, cap[base + i], (i < NOUT / 2) ? v0 : v1);
  endtask

  initial begin
    int base, c;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_pxl", pxl_out, 32'd0);
    reset = 1'b0;

    // Unit gain: 9 taps of 1.0 and of 0.5
    fill(32'h00010000, 32'h00010000, 32'h00008000);
    base = cap_n;
    load(1, 1, 1'b0);
    wait_out(base, NOUT);
    check_frame("unit", base, 32'h00090000, 32'h00048000);
    for (int i = 1; i < NOUT; i++)
      check("pulse_gap", 32'(cap_t[base + i] - cap_t[base + i - 1]), 32'(TAPS));
    repeat (10) @(negedge clk);
    check("hold_pxl", pxl_out, 32'h00048000);
    check("idle_valid", 32'(valid_out), 32'd0);

    // Ramp with centre tap: output order and tap addressing
    for (int i = 0; i < PN; i++) pix[i] = 32'(i << 16);
    for (int i = 0; i < WN; i++) wgt[i] = 32'h0;
    wgt[4] = 32'h00010000;
    base = cap_n;
    load(1, 1, 1'b0);
    wait_out(base, NOUT);
    for (int oy = 0; oy < 6; oy++)
      for (int ox = 0; ox < 6; ox++)
        check("ramp_co0", cap[base + oy * 6 + ox], 32'((((oy + 1) * 8) + ox + 1) << 16));
    for (int i = 36; i < NOUT; i++) check("ramp_co1", cap[base + i], 32'h0);

    // Negative weights
    fill(32'h00010000, 32'hFFFF0000, 32'hFFFF0000);
    base = cap_n;
    load(1, 1, 1'b0);
    wait_out(base, NOUT);
    check_frame("neg", base, 32'hFFF70000, 32'hFFF70000);

    // Positive saturation
    fill(32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000);
    base = cap_n;
    load(1, 1, 1'b0);
    wait_out(base, NOUT);
    check_frame("sat_pos", base, 32'h7FFFFFFF, 32'h7FFFFFFF);

    // Negative saturation
    fill(32'h80000000, 32'h7FFF0000, 32'h7FFF0000);
    base = cap_n;
    load(1, 1, 1'b0);
    wait_out(base, NOUT);
    check_frame("sat_neg", base, 32'h80000000, 32'h80000000);

    // Interleaved streams with gaps
    fill(32'h00010000, 32'h00010000, 32'h00008000);
    base = cap_n;
    load(2, 3, 1'b0);
    wait_out(base, NOUT);
    check_frame("gaps", base, 32'h00090000, 32'h00048000);

    // Extra words after saturation and words during compute
    base = cap_n;
    load(1, 4, 1'b1);
    wait_out(base, NOUT);
    check_frame("junk", base, 32'h00090000, 32'h00048000);

    // Reset after the 5th output aborts the frame
    base = cap_n;
    load(1, 1, 1'b0);
    c = 0;
    while (cap_n - base < 5 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(valid_out), 32'd0);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    check("rst_abort", 32'(cap_n - base), 32'd5);
    base = cap_n;
    load(1, 1, 1'b0);
    wait_out(base, NOUT);
    check_frame("reload", base, 32'h00090000, 32'h00048000);

    // Dilation 2: 4x4 outputs per channel
    use_d = 1'b1;
    fill(32'h00010000, 32'h00010000, 32'h00010000);
    base = capd_n;
    load(1, 1, 1'b0);
    c = 0;
    while (capd_n - base < 32 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    repeat (20) @(posedge clk);
    check("dil_count", 32'(capd_n - base), 32'd32);
    for (int i = 0; i < 32; i++) check("dil", capd[base + i], 32'h00090000);
    use_d = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cnn_conv_7x7_64.md
Name: cnn_conv_7x7_64

Overview:
- Streaming-load, sequential-compute 2-D convolution layer: the DeepLabV3+ stem conv, 7x7 kernel, 3 in-channels, 64 out-channels.
- Accepts one input frame and one full weight set as 32-bit word streams and buffers both internally.
- Then computes every output with a single pipelined multiply-accumulate unit and emits a 32-bit result stream.
- Sits between the pixel source and the next CNN stage; no bias, no activation.

Parameters:
- IMAGE_WIDTH, 1224, input frame width in pixels.
- IMAGE_HEIGHT, 1224, input frame height in pixels.
- CHANNEL_NUM_IN, 3, input channels.
- CHANNEL_NUM_OUT, 64, output channels.
- KERNEL, 7, square kernel size.
- RATE, 1, dilation rate; kernel taps spaced RATE pixels apart.
- DATA_WIDTH, 32, word width (fixed at 32; Q16.16).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  pxl_in carries an input pixel word this cycle.
- pxl_in  in  32  input pixel, signed Q16.16.
- valid_weight_in  in  1  weight_in carries a weight word this cycle.
- weight_in  in  32  kernel weight, signed Q16.16.
- pxl_out  out  32  output pixel, signed Q16.16.
- valid_out  out  1  pxl_out valid this cycle (one-cycle qualifier per word).

Behaviour:
- Derived sizes:
  - SPAN = (KERNEL-1)*RATE+1.
  - OUT_W = IMAGE_WIDTH-SPAN+1; OUT_H = IMAGE_HEIGHT-SPAN+1 ("valid" conv, stride 1, no padding).
  - PIX_NUM = CHANNEL_NUM_IN*IMAGE_WIDTH*IMAGE_HEIGHT.
  - WEIGHT_NUM = CHANNEL_NUM_OUT*CHANNEL_NUM_IN*KERNEL*KERNEL.
- Input order, channel-planar: ci, then row, then column (column fastest). Pixel address = (ci*IMAGE_HEIGHT+y)*IMAGE_WIDTH+x.
- Weight order: index = ((co*CHANNEL_NUM_IN+ci)*KERNEL+ky)*KERNEL+kx.
- Reset:
  - State LOAD; both write counters 0; compute counters 0; accumulator 0.
  - pxl_out=0, valid_out=0.
  - Buffer contents are not cleared; a full reload is required.
  - Reset mid-COMPUTE aborts the frame immediately; no further valid_out.
- State LOAD:
  - Each valid_in cycle writes pxl_in at pixel counter, then increments it; it saturates at PIX_NUM and extra words are dropped.
  - valid_weight_in behaves the same against WEIGHT_NUM.
  - The two streams are independent and may overlap on the same cycle.
  - When both counters are full, go to COMPUTE next cycle.
- State COMPUTE:
  - valid_in and valid_weight_in are ignored.
  - Loop order, outermost first: co, oy, ox, then MAC loop ci, ky, kx.
  - Tap address: pixel (ci, oy+ky*RATE, ox+kx*RATE); weight index as above.
  - Buffers are synchronous-read RAMs (1-cycle latency).
  - Pipeline stages: address, read, multiply, accumulate. One tap issued per cycle, no bubbles between output pixels.
- Arithmetic:
  - 32x32 signed product is 64-bit; accumulate in 64-bit signed, starting from 0 per output.
  - After the last tap: result = acc >>> 16 (arithmetic, truncate toward -inf), saturated to [0x80000000, 0x7FFFFFFF].
- Output:
  - result registered to pxl_out with valid_out=1 for exactly one cycle per output word.
  - Order: co-planar raster (co, oy, ox); total CHANNEL_NUM_OUT*OUT_H*OUT_W words.
  - valid_out pulses are spaced CHANNEL_NUM_IN*KERNEL*KERNEL cycles apart.
  - pxl_out holds its last value while valid_out=0.
- After the final output word: counters clear and the block returns to LOAD. The next frame needs both image and weights reloaded.

Decomposition:
- Package cnn_conv_pkg:
  - FRAC_BITS=16, ACC_WIDTH=64.
  - State encoding LOAD/COMPUTE.
  - Functions for SPAN/OUT_W/OUT_H and clog2-based address widths.
- Sub-module cnn_mac_q16: registered multiply, 64-bit accumulate with clear-on-first-tap, shift/saturate, done flag.
- Top contains both buffers, load counters, compute address generator and FSM.

Test Plan (small config: IMAGE 8x8, CHANNEL_NUM_IN=1, CHANNEL_NUM_OUT=2, KERNEL=3, unless noted):
- Unit-gain: all pixels 0x00010000; weights co0=0x00010000, co1=0x00008000 -> 72 outputs; first 36 = 0x00090000, last 36 = 0x00048000; valid_out pulses 9 cycles apart.
- Ramp/order: pixel(x,y)=(y*8+x)<<16; co0 centre tap 1.0, all others 0; co1 weights 0 -> co0 output (ox,oy) = ((oy+1)*8+ox+1)<<16 in raster order; co1 all 0x00000000.
- Sign/saturation:
  - weights 0xFFFF0000 with pixels 1.0 -> 0xFFF70000.
  - pixels 0x7FFF0000 with weights 0x7FFF0000 -> 0x7FFFFFFF.
  - pixels 0x80000000 with weights 0x7FFF0000 -> 0x80000000.
- Dilation: RATE=2, pixels 1.0, weights 1.0 -> 4x4x2=32 outputs, each 0x00090000.
- Overlap/ignore:
  - interleaved valid_in/valid_weight_in gaps during LOAD -> identical results to the unit-gain test.
  - extra words and words during COMPUTE -> no effect on outputs.
- Reset mid-COMPUTE, after the 5th valid_out -> valid_out stays 0; a full reload then yields the full correct 72-word sequence.
